// File: rtl/pmem_arbiter_rr.sv
// pmem_arbiter_rr: shares one physical memory port among NUM_PORTS cache
// clients. One block transaction is in flight at a time. Requests are latched
// on grant, so a client may drop its strobe mid-transaction without
// disturbing the memory access.
// Build option: define ARB_FIXED_PRIORITY_EN to replace round-robin with
// fixed priority, where the lowest requesting index always wins.
module pmem_arbiter_rr #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*BLOCK_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [BLOCK_WIDTH-1:0]           req_rdata,
    output logic                             pmem_read,
    output logic                             pmem_write,
    output logic [ADDR_WIDTH-1:0]            pmem_address,
    output logic [BLOCK_WIDTH-1:0]           pmem_wdata,
    input  logic                             pmem_resp,
    input  logic [BLOCK_WIDTH-1:0]           pmem_rdata,
    output logic [NUM_PORTS-1:0]             grant,
    output logic                             idle
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]             state_reg;
    logic                   pmem_read_reg;
    logic                   pmem_write_reg;
    logic [ADDR_WIDTH-1:0]  pmem_address_reg;
    logic [BLOCK_WIDTH-1:0] pmem_wdata_reg;
    logic [NUM_PORTS-1:0]   grant_reg;
`ifndef ARB_FIXED_PRIORITY_EN
    logic [IDX_W-1:0]       last_grant_reg;
`endif

    logic [NUM_PORTS-1:0]   req_any;
    logic [IDX_W-1:0]       winner_idx;
    logic [NUM_PORTS-1:0]   winner_onehot;
    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_PORTS];
    logic [BLOCK_WIDTH-1:0] wdata_arr [NUM_PORTS];

    assign req_any = req_read | req_write;

    // Unpack the flat per-port buses so the winner can be selected by index.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*BLOCK_WIDTH +: BLOCK_WIDTH];
        end
    endgenerate

`ifdef ARB_FIXED_PRIORITY_EN
    // Fixed priority: lowest requesting index wins (scan high to low, last hit sticks).
    always_comb begin
        winner_idx = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req_any[k]) begin
                winner_idx = IDX_W'(k);
            end
        end
    end
`else
    // Round-robin: first requester scanning upward from the port after last_grant.
    always_comb begin
        int  idx;
        logic found;
        winner_idx = '0;
        found      = 1'b0;
        idx        = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = int'(last_grant_reg) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!found && req_any[idx]) begin
                found      = 1'b1;
                winner_idx = IDX_W'(idx);
            end
        end
    end
`endif

    assign winner_onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << winner_idx;

    // Transaction FSM: latch the winner in IDLE, hold the memory strobe until pmem_resp.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            pmem_read_reg    <= 1'b0;
            pmem_write_reg   <= 1'b0;
            pmem_address_reg <= '0;
            pmem_wdata_reg   <= '0;
            grant_reg        <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            last_grant_reg   <= IDX_W'(NUM_PORTS - 1);
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (|req_any) begin
                        state_reg        <= S_BUSY;
                        grant_reg        <= winner_onehot;
                        // A port raising both strobes is treated as a write.
                        pmem_write_reg   <= req_write[winner_idx];
                        pmem_read_reg    <= ~req_write[winner_idx];
                        pmem_address_reg <= addr_arr[winner_idx];
                        pmem_wdata_reg   <= wdata_arr[winner_idx];
`ifndef ARB_FIXED_PRIORITY_EN
                        // Updating at grant time is equivalent to updating at
                        // completion: arbitration only happens again after the
                        // transaction ends, and reset overrides this value.
                        last_grant_reg   <= winner_idx;
`endif
                    end
                end
                S_BUSY: begin
                    if (pmem_resp) begin
                        state_reg      <= S_IDLE;
                        pmem_read_reg  <= 1'b0;
                        pmem_write_reg <= 1'b0;
                        grant_reg      <= '0;
                    end
                end
            endcase
        end
    end

    assign pmem_read    = pmem_read_reg;
    assign pmem_write   = pmem_write_reg;
    assign pmem_address = pmem_address_reg;
    assign pmem_wdata   = pmem_wdata_reg;
    assign grant        = grant_reg;

    // Completion goes straight back to the owner in the pmem_resp cycle.
    assign req_resp  = (state_reg == S_BUSY && pmem_resp) ? grant_reg : '0;
    assign req_rdata = pmem_rdata;
    assign idle      = (state_reg == S_IDLE) && !(|req_any);

endmodule

// File: doc/pmem_arbiter_rr.md
# pmem_arbiter_rr

Parametrised physical-memory arbiter that sits between N cache clients (icache, dcache, future victim/prefetch buffers) and the single physical memory port of the LC-3b pipeline top. Generalises the two-client icache/dcache arbiter to NUM_PORTS requesters. Round-robin grant, one outstanding block transaction at a time, registered request latching. Exposes an idle flag that the pipeline uses to gate its stage-register loads.

## Interface
- NUM_PORTS, 2, number of requesting clients (2..8)
- ADDR_WIDTH, 16, physical byte address width
- BLOCK_WIDTH, 128, cache line width in bits
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- req_read  input  NUM_PORTS  per-port line read request, held until its req_resp
- req_write  input  NUM_PORTS  per-port line write request, held until its req_resp
- req_address  input  NUM_PORTS*ADDR_WIDTH  port i address in bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  input  NUM_PORTS*BLOCK_WIDTH  port i write line, same packing
- req_resp  output  NUM_PORTS  one-hot completion pulse to the granted port
- req_rdata  output  BLOCK_WIDTH  read line, broadcast to all ports; valid only with req_resp
- pmem_read  output  1  read strobe to physical memory
- pmem_write  output  1  write strobe to physical memory
- pmem_address  output  ADDR_WIDTH  latched address
- pmem_wdata  output  BLOCK_WIDTH  latched write line
- pmem_resp  input  1  physical memory completion, one cycle
- pmem_rdata  input  BLOCK_WIDTH  physical memory read line
- grant  output  NUM_PORTS  one-hot owner of the in-flight transaction; 0 when idle
- idle  output  1  high in IDLE with no request pending (pipeline register load enable)

## Operation
- States: IDLE, BUSY.
- IDLE: if any port has req_read|req_write, select winner (round-robin: first requesting index scanning from last_grant+1 modulo NUM_PORTS). Latch winner index, address, wdata, direction (write wins if both strobes high on one port). Go to BUSY.
- BUSY: pmem_read/pmem_write driven from latched direction; pmem_address/pmem_wdata from latch. New requests are ignored. On pmem_resp: req_resp[grant_idx] = 1 combinationally same cycle, req_rdata = pmem_rdata pass-through, update last_grant = grant_idx, go to IDLE.
- Requester drops its strobe in the cycle it sees req_resp; the mandatory IDLE cycle after completion prevents re-granting the stale request.
- Requester dropping its strobe mid-transaction: latched transaction still completes; resp still pulsed.
- pmem_resp in IDLE: ignored, no req_resp.
- Reset (including mid-transaction): state IDLE, last_grant = NUM_PORTS-1 (port 0 wins first), pmem_read/pmem_write/req_resp/grant = 0, pmem_address/pmem_wdata latches = 0, idle = 1 once no request pending. In-flight transaction abandoned.

## Timing
- Request asserted at edge t (sampled in IDLE) -> pmem strobe high from t+1.
- Completion: req_resp same cycle as pmem_resp (zero added latency on response path).
- Minimum turnaround: one IDLE cycle between pmem_resp and next pmem strobe; back-to-back transactions cost pmem latency + 1 cycles.
- idle low from the cycle a request is seen through the pmem_resp cycle.
- Outputs pmem_read, pmem_write, pmem_address, pmem_wdata, grant are registered; req_resp, req_rdata, idle are combinational.

## Configuration
- ARB_FIXED_PRIORITY_EN defined: winner is lowest requesting index; last_grant ignored (port 0 may starve others).
- Undefined (default): round-robin as above; no port waits more than NUM_PORTS-1 transactions.

## Test plan
- Reset then port0 read 0x1230, pmem_resp after 3 cycles with rdata 0xA5..A5 -> pmem_read cycles 1-4, req_resp=0b01 in resp cycle, req_rdata=0xA5..A5, idle=1 next cycle.
- NUM_PORTS=2, both ports read continuously -> grants alternate 0,1,0,1; with ARB_FIXED_PRIORITY_EN grant stays 0.
- NUM_PORTS=4, ports 1 and 3 request after last_grant=3 -> port 1 first, then port 3.
- Port1 write 0x4000 wdata 0xDEAD.. while port0 read arrives in BUSY -> pmem_write with latched values unchanged; port0 served only after completion plus one IDLE cycle.
- rst asserted mid-BUSY -> next cycle pmem_read=0, grant=0, state IDLE; subsequent pmem_resp ignored; next grant goes to port 0.
- Port with req_read and req_write both high -> pmem_write issued, not pmem_read.
